// File: rtl/render_queue_writer.sv
// render_queue_writer
//   Producer side of the display render-queue byte interface. Software stages
//   sprite descriptors (x, y, sprite number, flags) through an 8-bit Avalon-MM
//   slave and commits them into a descriptor FIFO. On FRAME_DONE the block
//   arms, waits for the next vertical-blank pulse, clears the display queue,
//   then streams MAGIC, the entry count and every buffered descriptor, one
//   byte per cycle, oldest entry first.
//
// Ports
//   clk, reset          system clock, asynchronous active-high reset
//   chipselect, write,  Avalon slave select / write / read strobes
//   read
//   address[2:0]        register index (0-3 staging, 4 COMMIT, 5 FRAME_DONE,
//                       6 status / clear sticky flags, 7 FIFO count)
//   writedata[7:0]      write data
//   readdata[7:0]       registered read data, valid the cycle after a read
//   vblank_start        one-cycle pulse at start of vertical blanking
//   clear_render_queue  one-cycle pulse resetting the display queue pointer
//   render_queue_we     byte strobe into the display queue
//   render_queue_din    byte presented with render_queue_we
//   busy                high whenever the sequencer is not idle
module render_queue_writer #(
   parameter int         DEPTH = 63,
   parameter logic [7:0] MAGIC = 8'hA5
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       chipselect,
   input  logic       write,
   input  logic       read,
   input  logic [2:0] address,
   input  logic [7:0] writedata,
   output logic [7:0] readdata,
   input  logic       vblank_start,
   output logic       clear_render_queue,
   output logic       render_queue_we,
   output logic [7:0] render_queue_din,
   output logic       busy
);

   // DEPTH is at most 63 so the count always fits in 6 bits and the
   // zero-extended byte form equals {2'b0, count[5:0]}.
   localparam int CW = $clog2(DEPTH + 1);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ARMED,
      S_CLEAR,
      S_HDR,
      S_CNT,
      S_DATA
   } state_t;

   state_t          state_q;
   logic [7:0]      x_q, y_q, sp_q, fl_q;
   logic            ovf_q, rej_q;
   logic [CW-1:0]   count_q;
   logic [CW-1:0]   cnt_lat_q;
   logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
   logic [1:0]      lane_q;
   logic [7:0]      rdata_q;
   logic            clr_q, we_q;
   logic [7:0]      din_q;
   logic [31:0]     mem_q [DEPTH];

   logic            wr_en, rd_en;
   logic            commit, frame_done, clr_flags;
   logic            is_idle, fifo_full, push;
   logic [PW-1:0]   wr_ptr_d, rd_ptr_d;
   logic [31:0]     head_entry, next_entry;

   // Lane 0 is X (most significant byte) through lane 3 FLAGS.
   function automatic logic [7:0] lane_byte(input logic [31:0] e, input logic [1:0] l);
      case (l)
         2'd0:    return e[31:24];
         2'd1:    return e[23:16];
         2'd2:    return e[15:8];
         default: return e[7:0];
      endcase
   endfunction

   assign wr_en      = chipselect & write;
   assign rd_en      = chipselect & read;
   assign commit     = wr_en && (address == 3'd4);
   assign frame_done = wr_en && (address == 3'd5);
   assign clr_flags  = wr_en && (address == 3'd6);
   assign is_idle    = (state_q == S_IDLE);
   assign fifo_full  = (count_q == CW'(DEPTH));
   assign push       = commit && is_idle && !fifo_full;

   assign wr_ptr_d   = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
   assign rd_ptr_d   = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
   assign head_entry = mem_q[rd_ptr_q];
   assign next_entry = mem_q[rd_ptr_d];

   assign readdata           = rdata_q;
   assign clear_render_queue = clr_q;
   assign render_queue_we    = we_q;
   assign render_queue_din   = din_q;
   assign busy               = !is_idle;

   // Descriptor storage: data only, no reset needed.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= {x_q, y_q, sp_q, fl_q};
   end

   // Staging registers are always writable, even while busy.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         x_q  <= '0;
         y_q  <= '0;
         sp_q <= '0;
         fl_q <= '0;
      end else if (wr_en) begin
         case (address)
            3'd0:    x_q  <= writedata;
            3'd1:    y_q  <= writedata;
            3'd2:    sp_q <= writedata;
            3'd3:    fl_q <= writedata;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rdata_q <= '0;
      end else if (rd_en) begin
         case (address)
            3'd0:    rdata_q <= x_q;
            3'd1:    rdata_q <= y_q;
            3'd2:    rdata_q <= sp_q;
            3'd3:    rdata_q <= fl_q;
            3'd6:    rdata_q <= {busy, ovf_q, rej_q, 5'b0};
            3'd7:    rdata_q <= 8'(count_q);
            default: rdata_q <= '0;
         endcase
      end
   end

   // Sequencer. Output registers are loaded on the edge that enters the
   // state they belong to, so the clear pulse coincides with CLEAR and
   // stream byte k is visible k+1 cycles after it.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= S_IDLE;
         ovf_q     <= 1'b0;
         rej_q     <= 1'b0;
         count_q   <= '0;
         cnt_lat_q <= '0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         lane_q    <= '0;
         clr_q     <= 1'b0;
         we_q      <= 1'b0;
         din_q     <= '0;
      end else begin
         if (clr_flags) begin
            ovf_q <= 1'b0;
            rej_q <= 1'b0;
         end
         if ((commit || frame_done) && !is_idle) rej_q <= 1'b1;

         case (state_q)
            S_IDLE: begin
               clr_q <= 1'b0;
               we_q  <= 1'b0;
               din_q <= '0;
               if (push) begin
                  mem_wr_advance: begin
                     wr_ptr_q <= wr_ptr_d;
                     count_q  <= count_q + 1'b1;
                  end
               end
               if (commit && fifo_full) ovf_q <= 1'b1;
               if (frame_done) state_q <= S_ARMED;
            end
            S_ARMED: begin
               if (vblank_start) begin
                  state_q   <= S_CLEAR;
                  clr_q     <= 1'b1;
                  cnt_lat_q <= count_q;
               end
            end
            S_CLEAR: begin
               clr_q   <= 1'b0;
               we_q    <= 1'b1;
               din_q   <= MAGIC;
               state_q <= S_HDR;
            end
            S_HDR: begin
               din_q   <= 8'(cnt_lat_q);
               state_q <= S_CNT;
            end
            S_CNT: begin
               if (cnt_lat_q != '0) begin
                  din_q   <= lane_byte(head_entry, 2'd0);
                  lane_q  <= 2'd1;
                  state_q <= S_DATA;
               end else begin
                  we_q    <= 1'b0;
                  din_q   <= '0;
                  state_q <= S_IDLE;
               end
            end
            S_DATA: begin
               if (lane_q == 2'd0) begin
                  // FLAGS of the head entry has just been shown: retire it.
                  rd_ptr_q <= rd_ptr_d;
                  count_q  <= count_q - 1'b1;
                  if (count_q == CW'(1)) begin
                     we_q    <= 1'b0;
                     din_q   <= '0;
                     state_q <= S_IDLE;
                  end else begin
                     din_q  <= lane_byte(next_entry, 2'd0);
                     lane_q <= 2'd1;
                  end
               end else begin
                  din_q  <= lane_byte(head_entry, lane_q);
                  lane_q <= lane_q + 2'd1;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_render_queue_writer.sv
module tb_render_queue_writer;

   localparam int         DEPTH = 63;
   localparam logic [7:0] MAGIC = 8'hA5;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       chipselect = 1'b0;
   logic       write = 1'b0;
   logic       read = 1'b0;
   logic [2:0] address = '0;
   logic [7:0] writedata = '0;
   logic [7:0] readdata;
   logic       vblank_start = 1'b0;
   logic       clear_render_queue;
   logic       render_queue_we;
   logic [7:0] render_queue_din;
   logic       busy;

   render_queue_writer #(.DEPTH(DEPTH), .MAGIC(MAGIC)) dut (
      .clk                (clk),
      .reset              (reset),
      .chipselect         (chipselect),
      .write              (write),
      .read               (read),
      .address            (address),
      .writedata          (writedata),
      .readdata           (readdata),
      .vblank_start       (vblank_start),
      .clear_render_queue (clear_render_queue),
      .render_queue_we    (render_queue_we),
      .render_queue_din   (render_queue_din),
      .busy               (busy)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model: software-visible state only.
   logic [7:0]  m_stg [4];
   logic [31:0] m_fifo [$];
   bit          m_busy, m_ovf, m_rej;

   typedef struct {
      bit         is_wr;
      logic [2:0] addr;
      logic [7:0] data;
      logic [7:0] exp;
   } vec_t;

   vec_t tbl [$];

   function automatic vec_t mk(input bit w, input logic [2:0] a, input logic [7:0] d, input logic [7:0] e);
      vec_t v;
      v.is_wr = w; v.addr = a; v.data = d; v.exp = e;
      return v;
   endfunction

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   function automatic logic [7:0] m_read(input logic [2:0] a);
      case (a)
         3'd0, 3'd1, 3'd2, 3'd3: return m_stg[a[1:0]];
         3'd6:    return {m_busy, m_ovf, m_rej, 5'b0};
         3'd7:    return 8'(m_fifo.size());
         default: return 8'h00;
      endcase
   endfunction

   task automatic m_reset();
      for (int i = 0; i < 4; i++) m_stg[i] = 8'h00;
      m_fifo.delete();
      m_busy = 0; m_ovf = 0; m_rej = 0;
   endtask

   task automatic bus_write(input logic [2:0] a, input logic [7:0] d, input bit vb);
      case (a)
         3'd0, 3'd1, 3'd2, 3'd3: m_stg[a[1:0]] = d;
         3'd4: begin
            if (m_busy) m_rej = 1;
            else if (m_fifo.size() == DEPTH) m_ovf = 1;
            else m_fifo.push_back({m_stg[0], m_stg[1], m_stg[2], m_stg[3]});
         end
         3'd5: begin
            if (m_busy) m_rej = 1;
            else m_busy = 1;
         end
         3'd6: begin m_ovf = 0; m_rej = 0; end
         default: ;
      endcase
      chipselect = 1; write = 1; address = a; writedata = d; vblank_start = vb;
      @(posedge clk); #1;
      chipselect = 0; write = 0; vblank_start = 0;
   endtask

   task automatic bus_read(input logic [2:0] a, output logic [7:0] d);
      chipselect = 1; read = 1; address = a;
      @(posedge clk); #1;
      chipselect = 0; read = 0;
      d = readdata;
   endtask

   task automatic read_check(input string nm, input logic [2:0] a);
      logic [7:0] d;
      bus_read(a, d);
      check(nm, d, m_read(a));
   endtask

   task automatic do_reset();
      reset = 1;
      chipselect = 0; write = 0; read = 0; vblank_start = 0;
      #1;
      repeat (2) @(posedge clk);
      #1;
      reset = 0;
      m_reset();
   endtask

   // Pulse vblank while armed and compare the captured byte stream against
   // MAGIC, the entry count and the model FIFO contents.
   task automatic run_stream(input string nm);
      logic [7:0] expb [$];
      logic [7:0] got [$];
      bit         extra_clr = 0;
      bit         ended = 0;
      expb.push_back(MAGIC);
      expb.push_back(8'(m_fifo.size()));
      foreach (m_fifo[i]) begin
         logic [31:0] e;
         e = m_fifo[i];
         expb.push_back(e[31:24]);
         expb.push_back(e[23:16]);
         expb.push_back(e[15:8]);
         expb.push_back(e[7:0]);
      end
      vblank_start = 1;
      @(posedge clk); #1;
      vblank_start = 0;
      check({nm, " clear pulse"}, {clear_render_queue, render_queue_we}, 2'b10);
      for (int c = 0; c < 400; c++) begin
         @(posedge clk); #1;
         if (clear_render_queue) extra_clr = 1;
         if (!render_queue_we) begin ended = 1; break; end
         got.push_back(render_queue_din);
      end
      check({nm, " stream ended"}, ended, 1);
      check({nm, " single clear"}, extra_clr, 0);
      check({nm, " stream length"}, got.size(), expb.size());
      for (int i = 0; i < expb.size() && i < got.size(); i++)
         check($sformatf("%s byte%0d", nm, i), got[i], expb[i]);
      check({nm, " busy after"}, busy, 0);
      m_fifo.delete();
      m_busy = 0;
      read_check({nm, " count after"}, 3'd7);
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      logic [7:0] d;
      m_reset();

      // Reset state
      #1;
      check("reset outputs", {clear_render_queue, render_queue_we, render_queue_din, busy, readdata}, 18'h0);
      do_reset();
      check("post-reset outputs", {clear_render_queue, render_queue_we, render_queue_din, busy}, 11'h0);

      // Directed register table: reset reads, staging, two commits
      tbl.push_back(mk(0, 3'd6, 8'h00, 8'h00));
      tbl.push_back(mk(0, 3'd7, 8'h00, 8'h00));
      tbl.push_back(mk(1, 3'd0, 8'd10, 8'h00));
      tbl.push_back(mk(1, 3'd1, 8'd20, 8'h00));
      tbl.push_back(mk(1, 3'd2, 8'd1,  8'h00));
      tbl.push_back(mk(1, 3'd3, 8'd0,  8'h00));
      tbl.push_back(mk(0, 3'd0, 8'h00, 8'h0A));
      tbl.push_back(mk(0, 3'd1, 8'h00, 8'h14));
      tbl.push_back(mk(0, 3'd2, 8'h00, 8'h01));
      tbl.push_back(mk(0, 3'd3, 8'h00, 8'h00));
      tbl.push_back(mk(1, 3'd4, 8'h5A, 8'h00));
      tbl.push_back(mk(0, 3'd7, 8'h00, 8'h01));
      tbl.push_back(mk(0, 3'd0, 8'h00, 8'h0A));
      tbl.push_back(mk(1, 3'd0, 8'd30, 8'h00));
      tbl.push_back(mk(1, 3'd1, 8'd40, 8'h00));
      tbl.push_back(mk(1, 3'd2, 8'd2,  8'h00));
      tbl.push_back(mk(1, 3'd3, 8'd3,  8'h00));
      tbl.push_back(mk(1, 3'd4, 8'h00, 8'h00));
      tbl.push_back(mk(0, 3'd7, 8'h00, 8'h02));
      tbl.push_back(mk(0, 3'd6, 8'h00, 8'h00));
      tbl.push_back(mk(0, 3'd1, 8'h00, 8'h28));
      foreach (tbl[i]) begin
         if (tbl[i].is_wr) bus_write(tbl[i].addr, tbl[i].data, 0);
         else begin
            bus_read(tbl[i].addr, d);
            check($sformatf("tbl%0d rd a%0d", i, tbl[i].addr), d, tbl[i].exp);
         end
      end
      // readdata holds between reads
      @(posedge clk); #1;
      check("readdata hold", readdata, 8'h28);

      // Two-entry frame: A5,02,0A,14,01,00,1E,28,02,03
      bus_write(3'd5, 8'h00, 0);
      check("armed busy", busy, 1);
      repeat (3) @(posedge clk);
      #1;
      check("armed no clear", clear_render_queue, 0);
      run_stream("two");

      // Empty frame: A5,00 only
      bus_write(3'd5, 8'h00, 0);
      run_stream("empty");

      // Overflow: 64 commits into 63 slots
      for (int i = 0; i < 64; i++) begin
         bus_write(3'd0, 8'(i), 0);
         bus_write(3'd4, 8'h00, 0);
      end
      bus_read(3'd7, d); check("full count", d, 8'd63);
      bus_read(3'd6, d); check("ovf status", d, 8'h40);
      bus_write(3'd6, 8'h00, 0);
      bus_read(3'd6, d); check("flags cleared", d, 8'h00);

      // COMMIT while armed is rejected
      bus_write(3'd5, 8'h00, 0);
      bus_write(3'd4, 8'h00, 0);
      bus_read(3'd7, d); check("armed commit count", d, 8'd63);
      bus_read(3'd6, d); check("rej status", d, 8'hA0);
      run_stream("full");
      bus_write(3'd6, 8'h00, 0);

      // vblank coincident with FRAME_DONE is not seen
      bus_write(3'd0, 8'h77, 0);
      bus_write(3'd4, 8'h00, 0);
      bus_write(3'd5, 8'h00, 1);
      for (int i = 0; i < 4; i++) begin
         check($sformatf("coincident vb idle%0d", i), {clear_render_queue, render_queue_we, busy}, 3'b001);
         @(posedge clk); #1;
      end
      run_stream("coinc");

      // Reset during FLAGS byte of entry 0
      bus_write(3'd0, 8'h01, 0); bus_write(3'd1, 8'h02, 0);
      bus_write(3'd2, 8'h03, 0); bus_write(3'd3, 8'h04, 0);
      bus_write(3'd4, 8'h00, 0); bus_write(3'd4, 8'h00, 0);
      bus_write(3'd5, 8'h00, 0);
      vblank_start = 1;
      @(posedge clk); #1;
      vblank_start = 0;
      repeat (6) @(posedge clk);
      #1;
      check("mid-stream flags byte", {render_queue_we, render_queue_din}, 9'h104);
      reset = 1;
      #1;
      check("async reset outputs", {clear_render_queue, render_queue_we, render_queue_din, busy}, 11'h0);
      @(posedge clk); #1;
      reset = 0;
      m_reset();
      check("after reset busy", busy, 0);
      bus_read(3'd7, d); check("after reset count", d, 8'h00);
      read_check("after reset status", 3'd6);

      // Randomized rounds against the model
      for (int r = 0; r < 6; r++) begin
         int nops;
         nops = $urandom_range(10, 40);
         for (int k = 0; k < nops; k++) begin
            int kind;
            kind = $urandom_range(0, 9);
            case (kind)
               0, 1, 2, 3: bus_write(3'(kind), 8'($urandom), 0);
               4, 5: begin
                  int n;
                  n = (r == 2 && k == 0) ? 70 : $urandom_range(1, 3);
                  for (int j = 0; j < n; j++) bus_write(3'd4, 8'($urandom), 0);
               end
               6: begin
                  logic [2:0] a;
                  int sel;
                  sel = $urandom_range(0, 5);
                  a = (sel < 4) ? 3'(sel) : ((sel == 4) ? 3'd6 : 3'd7);
                  read_check($sformatf("rnd r%0d k%0d a%0d", r, k, a), a);
               end
               7: if ($urandom_range(0, 3) == 0) bus_write(3'd6, 8'h00, 0);
               8: begin
                  vblank_start = 1;
                  @(posedge clk); #1;
                  vblank_start = 0;
                  @(posedge clk); #1;
                  check($sformatf("idle vblank r%0d k%0d", r, k), {clear_render_queue, render_queue_we, busy}, 3'b000);
               end
               default: begin @(posedge clk); #1; end
            endcase
         end
         read_check($sformatf("rnd r%0d count", r), 3'd7);
         bus_write(3'd5, 8'h00, 0);
         repeat ($urandom_range(0, 5)) @(posedge clk);
         #1;
         if ($urandom_range(0, 1) == 1) begin
            bus_write(3'd4, 8'h00, 0);
            read_check($sformatf("rnd r%0d armed status", r), 3'd6);
         end
         run_stream($sformatf("rnd%0d", r));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/render_queue_writer.md
Name: render_queue_writer

Overview:
- Producer side of the display render-queue byte interface (`clear_render_queue`, `render_queue_we`, `render_queue_din`) consumed by the VGA display block.
- Software writes sprite descriptors (x, y, sprite number, flags) over an 8-bit Avalon-MM slave. Descriptors are buffered in an internal FIFO.
- On a frame-commit command, the block waits for the next vertical-blank pulse, clears the display's queue, then streams a header and all buffered descriptors as bytes, one byte per cycle.

Parameters:
- DEPTH, 63: descriptor FIFO capacity. 2+4*DEPTH must be ≤ 256, the display queue size.
- MAGIC, 8'hA5: header byte that opens every streamed frame list.

Ports:
- clk  in  1  system clock (50 MHz)
- reset  in  1  asynchronous, active-high
- chipselect  in  1  Avalon slave select
- write  in  1  Avalon write strobe
- read  in  1  Avalon read strobe
- address  in  3  register index
- writedata  in  8  write data
- readdata  out  8  registered read data
- vblank_start  in  1  one-cycle pulse at start of vertical blanking (from VGA timing)
- clear_render_queue  out  1  one-cycle pulse; display resets its queue write pointer
- render_queue_we  out  1  byte strobe into display queue
- render_queue_din  out  8  byte written when render_queue_we=1
- busy  out  1  high whenever state ≠ IDLE

Behaviour:
- Reset (asynchronous): all outputs are 0. State is IDLE, FIFO is empty, staging registers are 0, sticky flags are 0.

Register map:
- Writes take effect when chipselect&write.
- 0: X staging. 1: Y staging. 2: SPNUM staging. 3: FLAGS staging.
- 4: COMMIT (data ignored). Pushes {X,Y,SPNUM,FLAGS} as one 32-bit entry. Staging registers keep their values.
- 5: FRAME_DONE (data ignored). Moves IDLE→ARMED.
- 6: write clears sticky flags. Read returns {busy, ovf, rej, 5'b0}.
- 7: read returns {2'b0, count[5:0]}.
- Reads of addresses 0–3 return the staging value.
- readdata is registered and valid the cycle after chipselect&read. It holds its value otherwise.

Drop rules:
- COMMIT with FIFO full: entry dropped, ovf←1.
- COMMIT or FRAME_DONE while state ≠ IDLE: ignored, rej←1. Staging writes are always accepted.

State machine (one transition per clk):
- IDLE: accept COMMIT. FRAME_DONE → ARMED.
- ARMED: wait. On vblank_start → CLEAR. A vblank_start in the same cycle as the FRAME_DONE write is not seen; the block waits for the next one.
- CLEAR: clear_render_queue=1 for exactly this cycle, render_queue_we=0 → HDR.
- HDR: we=1, din=MAGIC → CNT.
- CNT: we=1, din={2'b0,count} → DATA if count>0, else IDLE.
- DATA: we=1 every cycle, bytes in order X,Y,SPNUM,FLAGS for each entry, oldest entry first.
  - The FIFO pops after the FLAGS byte of each entry.
  - After the last entry's FLAGS byte → IDLE with the FIFO empty.

Timing and arithmetic:
- Outputs are registered. Byte k of the stream appears k+1 cycles after the CLEAR cycle.
- Total stream is 1+2+4N cycles for N entries.
- count is latched at the ARMED→CLEAR transition. No pushes are possible after FRAME_DONE, so it equals the FIFO occupancy.
- Byte-lane counter is 2 bits and wraps 3→0. FIFO pointers wrap modulo DEPTH+1 storage or use an extra pointer bit; full = count==DEPTH.
- vblank_start outside ARMED is ignored.

Reset mid-stream:
- Outputs drop to 0 immediately. The FIFO is emptied and state returns to IDLE.
- The display may hold a partial list; software must re-issue the frame.

Test Plan:
- Reset, then read addr 6 and 7 → 8'h00 and 8'h00; all outputs 0.
- Push 2 entries {10,20,1,0} and {30,40,2,3}, FRAME_DONE, pulse vblank_start:
  - clear pulse for 1 cycle;
  - then we=1 for 10 consecutive cycles with din = A5,02,0A,14,01,00,1E,28,02,03;
  - then busy=0 and count=0.
- FRAME_DONE with empty FIFO, vblank_start → clear, then A5,00 only; back to IDLE after 3 cycles.
- 64 COMMITs with DEPTH=63 → count=63, addr 6 reads 8'h40. Write addr 6 → reads 8'h00.
- COMMIT while ARMED → count unchanged, rej set (addr 6 = 8'hA0 while busy).
- vblank_start in the same cycle as the FRAME_DONE write → no clear. The next vblank_start triggers the stream.
- Assert reset during the DATA byte 3 of entry 0 → we=0 immediately. After release, busy=0 and count=0.
